// File: rtl/nios2_seq_pkg.sv
// Shared definitions for the Nios II iteration sequencer.
// Holds the FSM state type, the register map and the register bit positions.
package nios2_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_TOTAL  = 2'd3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_DONE    = 1;
    localparam int STATUS_ABORT   = 2;
    localparam int STATUS_TIMEOUT = 3;

endpackage

// File: rtl/nios2_seq_watchdog.sv
// Per-step watchdog: reloads to all-ones at a step boundary and counts down while enabled.
// expire is combinational and marks the last allowed cycle (all-ones cycles spent in the step).
module nios2_seq_watchdog #(
    parameter int W = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '1;
        end else if (load) begin
            cnt <= '1;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = en && (cnt == W'(1));

endmodule

// File: rtl/nios2_iteration_sequencer.sv
// Runs the datapath for a software-programmed number of steps over valid/ready + done,
// reporting progress through a 4-word Avalon-MM slave and a level IRQ.
module nios2_iteration_sequencer
    import nios2_seq_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int TO_W  = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [CNT_W-1:0] iter_num,
    output logic             step_valid,
    input  logic             step_ready,
    output logic [CNT_W-1:0] step_index,
    input  logic             step_done
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count, total, count_inc;
    logic             irq_en;
    logic             done_flag, abort_flag, timeout_flag;
    logic             wr, ctrl_wr, status_wr, start, abort;
    logic             active, busy, abort_hit, timeout_hit;
    logic             wd_load, wd_expire;
    logic             unused_wdata;

    assign wr        = chipselect && !write_n;
    assign ctrl_wr   = wr && (address == ADDR_CTRL);
    assign status_wr = wr && (address == ADDR_STATUS);
    assign start     = ctrl_wr && writedata[CTRL_START];
    assign abort     = ctrl_wr && writedata[CTRL_ABORT];
    assign unused_wdata = ^writedata[31:4];

    assign count_inc = count + CNT_W'(1);
    assign active    = (state == ISSUE) || (state == WAIT);
    assign busy      = (state != IDLE);

    // Accept and step_done take priority over the watchdog so the datapath handshake stays coherent.
    always_comb begin
        state_nxt = state;
        wd_load   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (iter_num == '0) begin
                        state_nxt = FINISH;
                    end else begin
                        state_nxt = ISSUE;
                        wd_load   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (abort)           state_nxt = IDLE;
                else if (step_ready) state_nxt = WAIT;
                else if (wd_expire)  state_nxt = IDLE;
            end
            WAIT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (step_done) begin
                    if (count_inc == total) begin
                        state_nxt = FINISH;
                    end else begin
                        state_nxt = ISSUE;
                        wd_load   = 1'b1;
                    end
                end else if (wd_expire) begin
                    state_nxt = IDLE;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // From ISSUE/WAIT the only non-abort route back to IDLE is a watchdog expiry.
    assign abort_hit   = active && abort;
    assign timeout_hit = active && !abort && (state_nxt == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            total        <= '0;
            irq_en       <= 1'b0;
            done_flag    <= 1'b0;
            abort_flag   <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ctrl_wr) irq_en <= writedata[CTRL_IRQ_EN];

            if ((state == IDLE) && start) begin
                count <= '0;
                total <= iter_num;
            end else if ((state == WAIT) && step_done) begin
                count <= count_inc;
            end

            if ((state == IDLE) && start) begin
                done_flag    <= 1'b0;
                abort_flag   <= 1'b0;
                timeout_flag <= 1'b0;
            end else begin
                done_flag    <= (state == FINISH) || timeout_hit ||
                                (done_flag && !(status_wr && writedata[STATUS_DONE]));
                abort_flag   <= abort_hit ||
                                (abort_flag && !(status_wr && writedata[STATUS_ABORT]));
                timeout_flag <= timeout_hit ||
                                (timeout_flag && !(status_wr && writedata[STATUS_TIMEOUT]));
            end
        end
    end

    generate
        if (TO_W > 0) begin : g_wd
            nios2_seq_watchdog #(.W(TO_W)) u_wd (
                .clk    (clk),
                .reset  (reset),
                .load   (wd_load),
                .en     (active),
                .expire (wd_expire)
            );
        end else begin : g_no_wd
            assign wd_expire = 1'b0;
        end
    endgenerate

    assign step_valid = (state == ISSUE);
    assign step_index = count;
    assign irq        = done_flag && irq_en;

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:   readdata[CTRL_IRQ_EN] = irq_en;
            ADDR_STATUS: begin
                readdata[STATUS_BUSY]    = busy;
                readdata[STATUS_DONE]    = done_flag;
                readdata[STATUS_ABORT]   = abort_flag;
                readdata[STATUS_TIMEOUT] = timeout_flag;
            end
            ADDR_COUNT:  readdata[CNT_W-1:0] = count;
            ADDR_TOTAL:  readdata[CNT_W-1:0] = total;
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_nios2_iteration_sequencer.sv
// Randomized directed bench for the iteration sequencer; a second instance with a
// 4-bit watchdog exercises the timeout path.
module tb_nios2_iteration_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect, write_n;
    logic [31:0] writedata, readdata;
    logic        irq;
    logic [15:0] iter_num;
    logic        step_valid, step_ready, step_done;
    logic [15:0] step_index;

    logic [1:0]  w_addr;
    logic        w_cs, w_wn;
    logic [31:0] w_wdata, w_rdata;
    logic        w_irq;
    logic [15:0] w_iter;
    logic        w_valid, w_ready, w_done;
    logic [15:0] w_index;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nios2_iteration_sequencer dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
        .iter_num(iter_num), .step_valid(step_valid), .step_ready(step_ready),
        .step_index(step_index), .step_done(step_done)
    );

    nios2_iteration_sequencer #(.CNT_W(16), .TO_W(4)) dut_wd (
        .clk(clk), .reset(reset), .address(w_addr), .chipselect(w_cs),
        .write_n(w_wn), .writedata(w_wdata), .readdata(w_rdata), .irq(w_irq),
        .iter_num(w_iter), .step_valid(w_valid), .step_ready(w_ready),
        .step_index(w_index), .step_done(w_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic check_reg(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    // Drives one step up to (not including) its done pulse; ends in the WAIT phase.
    task automatic accept_step(input int k, input int rdly, input int ddly, input bit poke);
        for (int i = 0; i < rdly; i++) begin
            check("valid_hold", step_valid, 1);
            check("index_hold", step_index, 32'(k));
            if (poke && i == 2) wr(2'd0, 32'h5);
            else tick();
        end
        check("valid_issue", step_valid, 1);
        check("index_issue", step_index, 32'(k));
        step_ready = 1'b1;
        tick();
        step_ready = 1'b0;
        check("valid_after_accept", step_valid, 0);
        for (int i = 0; i < ddly; i++) begin
            tick();
            check("valid_in_wait", step_valid, 0);
        end
    endtask

    task automatic pulse_done();
        step_done = 1'b1;
        tick();
        step_done = 1'b0;
    endtask

    // Full run of n steps; the model is simply "index k issued k-th, COUNT = steps completed".
    task automatic run(input int n, input int first_rd, input bit poke);
        iter_num = 16'(n);
        wr(2'd0, 32'h5);
        iter_num = 16'($urandom);
        for (int k = 0; k < n; k++) begin
            int rdly;
            int ddly;
            rdly = (k == 0) ? first_rd : int'($urandom_range(0, 3));
            ddly = int'($urandom_range(0, 3));
            accept_step(k, rdly, ddly, poke);
            pulse_done();
            check_reg(2'd2, 32'(k + 1), "count_progress");
            if (k < n - 1) check("valid_next", step_valid, 1);
        end
        check_reg(2'd1, 32'h1, "status_finishing");
        tick();
        check_reg(2'd1, 32'h2, "status_done");
        check("irq_done", irq, 1);
        check_reg(2'd3, 32'(n), "total");
        check_reg(2'd2, 32'(n), "count_final");
    endtask

    initial begin
        reset = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        iter_num = '0; step_ready = 1'b0; step_done = 1'b0;
        w_addr = 2'd0; w_cs = 1'b0; w_wn = 1'b1; w_wdata = '0; w_iter = '0;
        w_ready = 1'b0; w_done = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_valid", step_valid, 0);
        check("rst_index", step_index, 0);
        check("rst_irq", irq, 0);
        check_reg(2'd0, 32'h0, "rst_ctrl");
        check_reg(2'd1, 32'h0, "rst_status");
        check_reg(2'd2, 32'h0, "rst_count");
        check_reg(2'd3, 32'h0, "rst_total");
        tick(); tick();
        reset = 1'b0;
        tick();

        // Basic 3-step run, then irq_en readback.
        run(3, 0, 1'b0);
        check_reg(2'd0, 32'h4, "ctrl_irq_en");

        // N = 0 goes straight to completion.
        iter_num = 16'd0;
        wr(2'd0, 32'h5);
        check("n0_no_valid", step_valid, 0);
        check_reg(2'd1, 32'h1, "n0_status_busy");
        tick();
        check("n0_no_valid2", step_valid, 0);
        check_reg(2'd1, 32'h2, "n0_status_done");
        check_reg(2'd2, 32'h0, "n0_count");

        // Ready held low for 10 cycles with an ignored start in the middle.
        run(5, 10, 1'b1);

        // Randomized runs.
        for (int r = 0; r < 6; r++) run(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), 1'b0);

        // Abort coinciding with step_done at COUNT=2 of 4.
        iter_num = 16'd4;
        wr(2'd0, 32'h5);
        for (int k = 0; k < 2; k++) begin
            accept_step(k, 0, 1, 1'b0);
            pulse_done();
        end
        accept_step(2, 0, 1, 1'b0);
        step_done = 1'b1;
        wr(2'd0, 32'h2);
        step_done = 1'b0;
        check("abort_valid", step_valid, 0);
        check_reg(2'd1, 32'h4, "abort_status");
        check_reg(2'd2, 32'h3, "abort_count");
        check("abort_irq", irq, 0);
        wr(2'd0, 32'h2);
        check_reg(2'd1, 32'h4, "abort_idle_noeffect");

        // Start and abort together while idle: the run starts.
        iter_num = 16'd1;
        wr(2'd0, 32'h3);
        check("start_abort_valid", step_valid, 1);
        check_reg(2'd1, 32'h1, "start_abort_status");
        accept_step(0, 0, 0, 1'b0);
        pulse_done();
        tick();
        check_reg(2'd1, 32'h2, "start_abort_done");
        check("start_abort_irq_off", irq, 0);
        wr(2'd1, 32'h2);
        check_reg(2'd1, 32'h0, "done_clear");

        // Watchdog expiry on the 4-bit instance.
        w_iter = 16'd3; w_ready = 1'b1;
        w_cs = 1'b1; w_wn = 1'b0; w_addr = 2'd0; w_wdata = 32'h5;
        tick();
        w_cs = 1'b0; w_wn = 1'b1; w_addr = 2'd1;
        repeat (14) tick();
        check("wd_still_busy", w_rdata, 32'h1);
        tick();
        check("wd_timeout_status", w_rdata, 32'hA);
        check("wd_irq", w_irq, 1);
        check("wd_valid", w_valid, 0);
        w_cs = 1'b1; w_wn = 1'b0; w_wdata = 32'hE;
        tick();
        w_cs = 1'b0; w_wn = 1'b1;
        check("wd_cleared", w_rdata, 32'h0);
        check("wd_irq_cleared", w_irq, 0);

        // Asynchronous reset while waiting on step_done.
        iter_num = 16'd3;
        wr(2'd0, 32'h5);
        accept_step(0, 0, 0, 1'b0);
        pulse_done();
        accept_step(1, 0, 0, 1'b0);
        reset = 1'b1;
        #1;
        check("arst_valid", step_valid, 0);
        check("arst_index", step_index, 0);
        check("arst_irq", irq, 0);
        check_reg(2'd1, 32'h0, "arst_status");
        check_reg(2'd2, 32'h0, "arst_count");
        check_reg(2'd3, 32'h0, "arst_total");
        check_reg(2'd0, 32'h0, "arst_ctrl");
        tick();
        reset = 1'b0;
        tick();
        run(2, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
